// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, EX redirect flushes, and mul/div occupancy.
// Optional perf counters are built when HAZARD_PERF_EN is defined; otherwise stall_cnt/flush_cnt read 0.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned MC_MAX_CYCLES = 64,
    parameter logic [6:0]  LOAD_OP       = 7'b0000011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_mc,
    input  logic [6:0]  ex_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wer,
    input  logic        ex_redirect,
    input  logic        mc_done,
    output logic        pc_en,
    output logic        pc_redirect,
    output logic        ifid_en,
    output logic        ifid_kill,
    output logic        idex_en,
    output logic        idex_kill,
    output logic        mc_start,
    output logic        mc_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, MC_WAIT, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [7:0] WD_LAST    = 8'(MC_MAX_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] flush_left_reg, flush_left_next;
    logic [7:0] wd_reg, wd_next;
    logic       timeout_reg, timeout_next;
    logic       load_use;

    assign load_use = (ex_op == LOAD_OP) && ex_wer && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            flush_left_reg <= 3'd0;
            wd_reg         <= 8'd0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            flush_left_reg <= flush_left_next;
            wd_reg         <= wd_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        flush_left_next = flush_left_reg;
        wd_next         = wd_reg;
        timeout_next    = timeout_reg;
        pc_en           = 1'b1;
        pc_redirect     = 1'b0;
        ifid_en         = 1'b1;
        ifid_kill       = 1'b0;
        idex_en         = 1'b1;
        idex_kill       = 1'b0;
        mc_start        = 1'b0;

        if (ex_redirect) begin
            // A redirect overrides every state and abandons any outstanding mc op.
            pc_redirect     = 1'b1;
            ifid_kill       = 1'b1;
            idex_kill       = 1'b1;
            state_next      = FLUSH;
            flush_left_next = FLUSH_LOAD;
            wd_next         = 8'd0;
        end else begin
            case (state_reg)
                RUN, LU_STALL: begin
                    state_next = RUN;
                    if ((state_reg == RUN) && load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_kill  = 1'b1;
                        state_next = LU_STALL;
                    end else if (id_mc) begin
                        mc_start   = 1'b1;
                        state_next = MC_WAIT;
                        wd_next    = 8'd0;
                    end
                end
                MC_WAIT: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    if (mc_done) begin
                        // Result retires from ID/EX; refill it with a bubble.
                        idex_en    = 1'b1;
                        idex_kill  = 1'b1;
                        state_next = RUN;
                        wd_next    = 8'd0;
                    end else begin
                        idex_en = 1'b0;
                        if (wd_reg == WD_LAST) begin
                            timeout_next = 1'b1;
                            state_next   = RUN;
                            wd_next      = 8'd0;
                        end else begin
                            wd_next = wd_reg + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    ifid_kill = 1'b1;
                    idex_kill = 1'b1;
                    if (flush_left_reg <= 3'd1) begin
                        state_next = RUN;
                    end else begin
                        flush_left_next = flush_left_reg - 3'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end

        if (!rst_n) begin
            pc_en       = 1'b0;
            pc_redirect = 1'b0;
            ifid_en     = 1'b0;
            ifid_kill   = 1'b1;
            idex_en     = 1'b1;
            idex_kill   = 1'b1;
            mc_start    = 1'b0;
        end
    end

    assign mc_timeout = timeout_reg;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            if (!pc_en) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (ex_redirect) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the enable (flag) and kill (pc_replace) inputs of the IF/ID and ID/EX pipeline registers, plus the PC enable/redirect select.
- Resolves load-use hazards, EX-stage branch/jump redirects, and multi-cycle (mul/div) unit occupancy with a small FSM.
- Sits beside the decode stage; takes ID-stage operand info and EX-stage (DE_*) outputs.

Parameters:
- FLUSH_CYCLES, 1, extra bubble cycles held after a redirect; legal range 1..7.
- MC_MAX_CYCLES, 64, watchdog limit for multi-cycle op completion; legal range 2..255.
- LOAD_OP, 7'b0000011, opcode identifying loads in EX.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_mc  in  1  ID instruction is multi-cycle (mul/div)
- ex_op  in  7  opcode in EX (ID/EX DE_op_out)
- ex_rd  in  5  destination in EX (DE_rd_out)
- ex_wer  in  1  EX register write enable (DE_wer_out)
- ex_redirect  in  1  EX resolved taken branch/jump; 1-cycle pulse
- mc_done  in  1  multi-cycle unit result valid; 1-cycle pulse
- pc_en  out  1  PC update enable
- pc_redirect  out  1  select EX target into PC
- ifid_en  out  1  IF/ID register load enable
- ifid_kill  out  1  IF/ID insert bubble
- idex_en  out  1  ID/EX load enable (flag)
- idex_kill  out  1  ID/EX bubble (pc_replace)
- mc_start  out  1  launch multi-cycle op; 1-cycle pulse
- mc_timeout  out  1  sticky watchdog error
- stall_cnt  out  32  perf: stall cycles (optional)
- flush_cnt  out  32  perf: redirect events (optional)

Behaviour:
- States: RUN, LU_STALL, MC_WAIT, FLUSH. Reset (rst_n=0 at posedge) → RUN, counters 0, mc_timeout 0.
- While rst_n=0, outputs are forced: pc_en=0, pc_redirect=0, ifid_en=0, ifid_kill=1, idex_en=1, idex_kill=1, mc_start=0.
- Outputs are combinational from state + inputs (same-cycle action). State/counters are registered.
- Default in RUN with no event: pc_en=ifid_en=idex_en=1, kills=0.
- Priority, high→low: ex_redirect, load-use, id_mc.
- Redirect (any state):
  - Same cycle: pc_redirect=1, pc_en=1, ifid_kill=1, idex_kill=1, idex_en=1.
  - Next state FLUSH with down-counter=FLUSH_CYCLES.
  - Aborts LU_STALL; in MC_WAIT, the mc op is abandoned, watchdog is cleared, and a later mc_done is ignored.
- FLUSH:
  - ifid_kill=1, idex_kill=1, pc_en=1.
  - Counter decrements each cycle; at 1 → RUN.
- Load-use (RUN):
  - Condition: ex_op==LOAD_OP, ex_wer, ex_rd!=0, and (id_use_rs1 & id_rs1==ex_rd or id_use_rs2 & id_rs2==ex_rd).
  - Action: pc_en=0, ifid_en=0, idex_en=1, idex_kill=1.
  - → LU_STALL for exactly 1 cycle (normal outputs), then RUN.
  - The load-use check is not re-run in LU_STALL; the load has left EX.
- Multi-cycle (RUN, id_mc=1, no hazard):
  - mc_start=1 for one cycle; instruction loads into ID/EX.
  - → MC_WAIT: pc_en=0, ifid_en=0, idex_en=0 (hold).
  - mc_done → RUN that cycle, with idex_en=1 and idex_kill=1 in the done cycle.
  - mc_done in the same cycle as mc_start is ignored.
  - Watchdog counts MC_WAIT cycles; on reaching MC_MAX_CYCLES: mc_timeout←1 (sticky until reset) and → RUN.
- Reset mid-stall/flush/MC_WAIT: immediate return to RUN, no pulses emitted.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cnt increments each cycle pc_en=0 with rst_n=1.
  - flush_cnt increments on each ex_redirect.
  - Both are 32-bit, wrap at 2^32−1→0, and clear on reset.
- HAZARD_PERF_EN undefined: counters are not built; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Reset held 3 cycles, then released → during reset pc_en=0, idex_kill=1; first cycle after release pc_en=ifid_en=idex_en=1, kills=0.
- ex_op=0000011, ex_wer=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle pc_en=0, idex_kill=1, then RUN. Repeat with ex_rd=0 → no stall.
- ex_redirect pulse with FLUSH_CYCLES=2 → pc_redirect=1 for 1 cycle, ifid_kill=1 for 3 cycles total, then normal; flush_cnt=1.
- id_mc=1, mc_done 10 cycles after mc_start → mc_start single pulse, pc_en=0 for 10 cycles, idex_en=0 during wait, RUN after done; stall_cnt=10.
- id_mc=1 with no mc_done, MC_MAX_CYCLES=8 → mc_timeout=1 after 8 wait cycles, stays 1 until rst_n=0.
- Load-use and ex_redirect asserted in the same cycle → redirect wins (pc_redirect=1, pc_en=1), FSM → FLUSH, no LU_STALL entered.
